// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Decode substitutes INST_NOP on cycles where the fetch queue has nothing valid.
package fetch_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] inst;
    logic                misalign;
  } fetch_entry_t;

  // RISC-V fetch requires a 4-byte aligned PC; any low bit set is reported to decode.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return |pc_lsb;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetch entries with a synchronous clear that discards all contents.
// Storage is not reset; the head output reads as zero whenever the queue is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  entry_t                 wdata_i,
  input  logic                   pop_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en;
  logic            pop_en;

  always_comb begin
    wr_en   = wr_i & ~clr_i;
    pop_en  = pop_i & ~clr_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      // Clearing leaves the read side untouched and just collapses the write pointer onto it.
      count_d = '0;
      wptr_d  = rptr_q;
    end else begin
      if (wr_en)  wptr_d = wptr_q + PW'(1);
      if (pop_en) rptr_d = rptr_q + PW'(1);
      case ({wr_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    rdata_o = '0;
    if (count_q != '0) rdata_o = mem_q[rptr_q];
  end

  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: issues PCs to a one-cycle-latency instruction memory and
// queues {pc, inst, misalign} for decode, with flush for taken jumps/branches.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] insmemaddr_o,
  output logic            insmemreq_o,
  input  logic [XLEN-1:0] insmemdata_i,
  output logic            valid_ro,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_ro,
  output logic [XLEN-1:0] inst_ro,
  output logic            misalign_ro
);

  // Handshakes on both sides transfer on a cycle where valid and ready are both high at
  // the rising edge; a producer holds its payload stable until that transfer, and
  // flush_i forces both ready_o and valid_ro low so neither side transfers that cycle.

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } q_entry_t;

  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_mis_q, pend_mis_d;

  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [CW:0]     occ_after_pop;
  logic            fire_in;
  logic            pop;
  logic            wr;
  q_entry_t        wdata;
  q_entry_t        head;

  // Credit check counts the in-flight fetch, so a returning word always has a free slot.
  always_comb begin
    valid_ro      = (count != '0) & ~flush_i;
    pop           = valid_ro & ready_i;
    occ           = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    occ_after_pop = occ - {{CW{1'b0}}, pop};
    ready_o       = ~flush_i & (occ_after_pop < DEPTH_W);
    fire_in       = valid_i & ready_o;
    wr            = inflight_q & ~flush_i;
    wdata.pc       = pend_pc_q;
    wdata.inst     = insmemdata_i;
    wdata.misalign = pend_mis_q;
  end

  always_comb begin
    inflight_d = fire_in;
    pend_pc_d  = pend_pc_q;
    pend_mis_d = pend_mis_q;
    if (fire_in) begin
      pend_pc_d  = pc_i;
      pend_mis_d = pc_misaligned(pc_i[1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      pend_pc_q  <= '0;
      pend_mis_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      pend_pc_q  <= pend_pc_d;
      pend_mis_q <= pend_mis_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (q_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .wr_i    (wr),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    insmemaddr_o = pc_i;
    insmemreq_o  = fire_in;
    pc_ro        = head.pc;
    inst_ro      = head.inst;
    misalign_ro  = head.misalign;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: accepted PCs push expected entries, a monitor
// pops and compares every head transfer, plus directed timing/flag checks.
module tb_ifetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int W     = 2 * XLEN + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [XLEN-1:0] pc_i = '0;
  logic            flush_i = 1'b0;
  logic [XLEN-1:0] insmemaddr_o;
  logic            insmemreq_o;
  logic [XLEN-1:0] insmemdata_i = '0;
  logic            valid_ro;
  logic            ready_i = 1'b0;
  logic [XLEN-1:0] pc_ro;
  logic [XLEN-1:0] inst_ro;
  logic            misalign_ro;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory: returns address + 0x100 one cycle later
  always @(posedge clk) insmemdata_i <= insmemaddr_o + 32'h100;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .insmemaddr_o (insmemaddr_o),
    .insmemreq_o  (insmemreq_o),
    .insmemdata_i (insmemdata_i),
    .valid_ro     (valid_ro),
    .ready_i      (ready_i),
    .pc_ro        (pc_ro),
    .inst_ro      (inst_ro),
    .misalign_ro  (misalign_ro)
  );

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [XLEN-1:0] pc);
    return {pc, pc + 32'h100, |pc[1:0]};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (valid_ro && ready_i) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop got %h exp none", {pc_ro, inst_ro, misalign_ro});
        end else begin
          checkw("head_entry", {pc_ro, inst_ro, misalign_ro}, exp_q.pop_front());
        end
      end
      if (flush_i) exp_q.delete();
      if (valid_i && ready_o) exp_q.push_back(model(pc_i));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [XLEN-1:0] pc);
    bit done = 1'b0;
    int n = 0;
    valid_i = 1'b1;
    pc_i    = pc;
    while (!done && n < 50) begin
      @(negedge clk);
      if (ready_o) done = 1'b1;
      step();
      n++;
    end
    valid_i = 1'b0;
    if (!done) check1("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    ready_i = 1'b1;
    while ((exp_q.size() != 0 || valid_ro) && n < 40) begin
      step();
      n++;
    end
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
    check1("drain_valid_low", valid_ro, 1'b0);
  endtask

  initial begin
    int pops0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid_ro", valid_ro, 1'b0);
    check32("rst_pc_ro", pc_ro, 32'h0);
    check32("rst_inst_ro", inst_ro, 32'h0);
    check1("rst_misalign_ro", misalign_ro, 1'b0);
    check1("rst_ready_o", ready_o, 1'b1);
    rst = 1'b0;
    step();

    // streaming: 0x0, 0x4, 0x8 back to back
    ready_i = 1'b1;
    valid_i = 1'b1;
    pc_i    = 32'h0;
    step();
    pc_i = 32'h4;
    check1("stream_latency_low", valid_ro, 1'b0);
    step();
    pc_i = 32'h8;
    check1("stream_valid_c2", valid_ro, 1'b1);
    check32("stream_pc0", pc_ro, 32'h0);
    check32("stream_inst0", inst_ro, 32'h100);
    step();
    valid_i = 1'b0;
    check32("stream_pc1", pc_ro, 32'h4);
    check32("stream_inst1", inst_ro, 32'h104);
    step();
    check32("stream_pc2", pc_ro, 32'h8);
    check32("stream_inst2", inst_ro, 32'h108);
    step();
    check1("stream_done_low", valid_ro, 1'b0);
    drain();

    // backpressure / full
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'(i * 4);
      @(negedge clk);
      check1("bp_accept", ready_o, 1'b1);
      step();
    end
    pc_i = 32'h10;
    @(negedge clk);
    check1("bp_full_inflight", ready_o, 1'b0);
    step();
    @(negedge clk);
    check1("bp_full_count", ready_o, 1'b0);
    step();
    ready_i = 1'b1;
    @(negedge clk);
    check1("bp_full_with_pop", ready_o, 1'b1);
    step();
    ready_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check1("bp_refull", ready_o, 1'b0);
    step();
    drain();

    // flush mid-stream: 0x4/0x8/0xc queued, 0x10 in flight
    ready_i = 1'b0;
    send(32'h4);
    send(32'h8);
    send(32'hc);
    send(32'h10);
    flush_i = 1'b1;
    @(negedge clk);
    check1("flush_ready_low", ready_o, 1'b0);
    check1("flush_valid_low", valid_ro, 1'b0);
    step();
    flush_i = 1'b0;
    check1("post_flush_empty", valid_ro, 1'b0);
    ready_i = 1'b1;
    valid_i = 1'b1;
    pc_i    = 32'h200;
    step();
    valid_i = 1'b0;
    check1("redirect_latency_low", valid_ro, 1'b0);
    step();
    check1("redirect_valid", valid_ro, 1'b1);
    check32("redirect_pc", pc_ro, 32'h200);
    drain();

    // wrap-around with alternating ready_i
    pops0   = n_pops;
    ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'(i * 4));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          ready_i = ~ready_i;
          step();
        end
      end
    join
    drain();
    check32("wrap_pop_count", 32'(n_pops - pops0), 32'd10);

    // misaligned PC
    ready_i = 1'b0;
    send(32'h6);
    send(32'h8);
    step();
    check32("mis_pc", pc_ro, 32'h6);
    check1("mis_flag_set", misalign_ro, 1'b1);
    ready_i = 1'b1;
    step();
    check32("aligned_pc", pc_ro, 32'h8);
    check1("mis_flag_clear", misalign_ro, 1'b0);
    drain();

    // reset mid-operation: two queued, one in flight
    ready_i = 1'b0;
    send(32'h0);
    send(32'h4);
    valid_i = 1'b1;
    pc_i    = 32'h8;
    step();
    valid_i = 1'b0;
    rst     = 1'b1;
    #1;
    check1("midrst_valid_ro", valid_ro, 1'b0);
    check32("midrst_pc_ro", pc_ro, 32'h0);
    check32("midrst_inst_ro", inst_ro, 32'h0);
    check1("midrst_misalign_ro", misalign_ro, 1'b0);
    step();
    rst     = 1'b0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    pc_i    = 32'h40;
    step();
    valid_i = 1'b0;
    check1("after_rst_latency_low", valid_ro, 1'b0);
    step();
    check1("after_rst_valid", valid_ro, 1'b1);
    check32("after_rst_pc", pc_ro, 32'h40);
    check32("after_rst_inst", inst_ro, 32'h140);
    drain();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch stage for the RISC-V pipeline, placed between the PC generator and decode. It accepts PCs over a valid/ready handshake, issues them to a synchronous instruction memory with one-cycle read latency, and buffers the returned `{pc, inst, misalign}` entries in a DEPTH-entry queue drained by decode. A flush input discards all queued and in-flight fetches on a taken jump or branch.

## Interface
- `XLEN`, 32: PC and instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_i` in 1: upstream PC valid.
- `ready_o` out 1: upstream accept.
- `pc_i` in XLEN: fetch PC.
- `flush_i` in 1: discard all queued and in-flight entries this cycle.
- `insmemaddr_o` out XLEN: instruction memory address; equals `pc_i`.
- `insmemreq_o` out 1: memory read strobe; equals `valid_i & ready_o`.
- `insmemdata_i` in XLEN: read data, valid the cycle after the strobe.
- `valid_ro` out 1: queue head valid to decode.
- `ready_i` in 1: decode accept.
- `pc_ro` out XLEN: head PC.
- `inst_ro` out XLEN: head instruction.
- `misalign_ro` out 1: head PC had `pc[1:0] != 0`.

## Operation
- **Accept:** `fire_in = valid_i & ready_o`; `pop = valid_ro & ready_i`.
- **Occupancy:** `occ = count + inflight`. `count` is the number of queue entries, width `$clog2(DEPTH)+1`. `inflight` is 0 or 1.
- **Ready:** `ready_o = ~flush_i & (occ - pop < DEPTH)`. This is combinational from `ready_i`, which allows full throughput at DEPTH ≥ 2.
- **Request tracking:**
  - On `fire_in`, register `pend_pc <= pc_i` and `pend_mis <= |pc_i[1:0]`, and set `inflight <= 1`.
  - Otherwise, `inflight <= 0`.
- **Memory return:** in the cycle after a request, if `inflight` is set and was not killed, write `{pend_pc, insmemdata_i, pend_mis}` at `wptr`. Then `wptr++` and `count++`.
- **Pop:** on `pop`, `rptr++` and `count--`. A simultaneous write and pop leaves `count` unchanged.
- **Pointer wrap:** `wptr` and `rptr` are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **Head outputs:** `valid_ro = (count != 0) & ~flush_i`. `pc_ro`, `inst_ro` and `misalign_ro` come from the entry at `rptr`.
- **Flush:** when `flush_i=1`:
  - `ready_o=0` and `valid_ro=0`; no accept and no pop occur.
  - At the edge: `count<=0`, `wptr<=rptr`, `inflight<=0`.
  - Any return data arriving that cycle is dropped.
  - A request issued in the cycle before the flush returns during the flush cycle and is discarded.
  - `pc_i` after the flush is the redirect target.
- **Misalignment:** a misaligned PC is still fetched and queued. Decode raises the exception from `misalign_ro`.
- **Memory:** there is no back-pressure from memory; memory always returns data the next cycle.

## Timing
- **Reset:** asserting `rst`, at any time including mid-operation, forces:
  - `count=0`, `inflight=0`, `wptr=rptr=0`;
  - `valid_ro=0`, `pc_ro=0`, `inst_ro=0`, `misalign_ro=0`.
- **Queue storage:** the queue array is not reset; the head output mux is forced to zero when empty.
- **Latency:** a PC accepted at edge N appears on `valid_ro` after edge N+1 (two-cycle fetch-to-decode). There is no bypass from memory to output.
- **Throughput:** one instruction per cycle when `ready_i` stays high.
- **Full:** `ready_o=0` while `occ == DEPTH` and no pop occurs.
- **Full with pop:** at `occ == DEPTH` with a pop, `ready_o=1`.
- **Empty:** `valid_ro=0`; `pop` is impossible.
- **Handshake rules:**
  - `valid_ro` and head data stay stable until `pop` or `flush_i`.
  - `valid_i` may drop without an accept.
- **Flush with return:** a return and `flush_i` in the same cycle means the flush wins.
- **Flush with request:** a request and `flush_i` in the same cycle cannot occur, because `ready_o=0`.

## Structure
- **Package `fetch_pkg`:**
  - `XLEN` default;
  - `fetch_entry_t` struct `{pc, inst, misalign}`;
  - `INST_NOP = 32'h00000013`, for decode's use on invalid cycles.
- **Sub-module `fetch_fifo`:**
  - Parametrised by `DEPTH` and entry type.
  - Contains pointers, count, write/pop and synchronous clear.
- **`ifetch_queue` top:** holds the in-flight register, ready/credit logic and flush gating.

## Test plan
- **Streaming:** DEPTH=4, `ready_i=1`, PCs 0x0, 0x4, 0x8 on consecutive cycles, memory returns PC+0x100 -> `valid_ro` high from cycle 2, `pc_ro` 0x0/0x4/0x8 with `inst_ro` 0x100/0x104/0x108 on consecutive cycles.
- **Backpressure/full:** `ready_i=0`, push 0x0..0x10 -> four entries accepted, `ready_o` low at `occ=4`. Raising `ready_i` for one cycle -> `ready_o` high that same cycle, and a fifth PC is accepted.
- **Flush mid-stream:** three entries queued plus one in flight, `flush_i` pulse, then PC 0x200 -> the old entries and the in-flight 0x10 never appear; the next `valid_ro` shows `pc_ro=0x200`.
- **Wrap-around:** 10 PCs through DEPTH=4 with alternating `ready_i` -> in-order output 0x0..0x24, with no loss or duplication across the pointer wrap.
- **Misaligned:** PC 0x6 -> `misalign_ro=1`, `pc_ro=0x6`; the following PC 0x8 gives `misalign_ro=0`.
- **Reset mid-operation:** assert `rst` with two entries and one in flight -> all outputs 0 immediately. After release, PC 0x40 emerges first, two cycles after its accept.
